id_ex_stage: RTL and testbench

ID/EX pipeline boundary for the 5-stage MIPS core. It registers the grouped EX/MEM/WB control fields from the main control unit together with decode-stage operands, and forwards them to the execute stage. It contains the load-use hazard detector, which stalls PC and IF/ID and inserts a bubble. It also squashes the decode instruction on a branch flush and keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_if.sv | 46 ++++
 rtl/id_ex_stage.sv | 53 +++++
 tb/tb_id_ex_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// id_ex_if: decode-side inputs, registered execute-side outputs and hazard controls of the ID/EX boundary
interface id_ex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH = 16
);
  logic [3:0] ex_control_in;
  logic [2:0] mem_control_in;
  logic [1:0] wb_control_in;
  logic [DATA_WIDTH-1:0] pc_plus4_in;
  logic [DATA_WIDTH-1:0] read_data1_in;
  logic [DATA_WIDTH-1:0] read_data2_in;
  logic [DATA_WIDTH-1:0] sign_ext_imm_in;
  logic [REG_ADDR_WIDTH-1:0] rs_in;
  logic [REG_ADDR_WIDTH-1:0] rt_in;
  logic [REG_ADDR_WIDTH-1:0] rd_in;
  logic flush;
  logic [3:0] ex_control_out;
  logic [2:0] mem_control_out;
  logic [1:0] wb_control_out;
  logic [DATA_WIDTH-1:0] pc_plus4_out;
  logic [DATA_WIDTH-1:0] read_data1_out;
  logic [DATA_WIDTH-1:0] read_data2_out;
  logic [DATA_WIDTH-1:0] sign_ext_imm_out;
  logic [REG_ADDR_WIDTH-1:0] rs_out;
  logic [REG_ADDR_WIDTH-1:0] rt_out;
  logic [REG_ADDR_WIDTH-1:0] rd_out;
  logic valid_out;
  logic pc_write;
  logic if_id_write;
  logic [COUNT_WIDTH-1:0] bubble_count;
  modport master (
    output ex_control_in, mem_control_in, wb_control_in, pc_plus4_in, read_data1_in,
           read_data2_in, sign_ext_imm_in, rs_in, rt_in, rd_in, flush,
    input  ex_control_out, mem_control_out, wb_control_out, pc_plus4_out, read_data1_out,
           read_data2_out, sign_ext_imm_out, rs_out, rt_out, rd_out, valid_out,
           pc_write, if_id_write, bubble_count
  );
  modport slave (
    input  ex_control_in, mem_control_in, wb_control_in, pc_plus4_in, read_data1_in,
           read_data2_in, sign_ext_imm_in, rs_in, rt_in, rd_in, flush,
    output ex_control_out, mem_control_out, wb_control_out, pc_plus4_out, read_data1_out,
           read_data2_out, sign_ext_imm_out, rs_out, rt_out, rd_out, valid_out,
           pc_write, if_id_write, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush squash and saturating bubble counter
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  id_ex_if.slave bus
);
  localparam int DW = 4 * DATA_WIDTH + 3 * REG_ADDR_WIDTH;
  logic hazard, stall, bubble;
  logic [8:0] ctrl_q, ctrl_d;
  logic valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  // load-use detection against the registered load; flush overrides the stall but still bubbles
  always_comb begin
    hazard = bus.mem_control_out[2] & (bus.rt_out != '0) &
             ((bus.rt_out == bus.rs_in) | (bus.rt_out == bus.rt_in));
    stall = hazard & ~bus.flush;
    bubble = hazard | bus.flush;
    bus.pc_write = ~stall;
    bus.if_id_write = ~stall;
  end
  // next register contents: data always captured, control zeroed and counter bumped on a bubble
  always_comb begin
    ctrl_d = bubble ? 9'd0 : {bus.ex_control_in, bus.mem_control_in, bus.wb_control_in};
    valid_d = ~bubble;
    data_d = {bus.pc_plus4_in, bus.read_data1_in, bus.read_data2_in, bus.sign_ext_imm_in,
              bus.rs_in, bus.rt_in, bus.rd_in};
    count_d = (bubble && count_q != '1) ? count_q + 1'b1 : count_q;
  end
  // pipeline state with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      count_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      valid_q <= valid_d;
      data_q <= data_d;
      count_q <= count_d;
    end
  end
  assign {bus.ex_control_out, bus.mem_control_out, bus.wb_control_out} = ctrl_q;
  assign {bus.pc_plus4_out, bus.read_data1_out, bus.read_data2_out, bus.sign_ext_imm_out,
          bus.rs_out, bus.rt_out, bus.rd_out} = data_q;
  assign bus.valid_out = valid_q;
  assign bus.bubble_count = count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, load-use stall, flush, reset and counter saturation
module tb_id_ex_stage;
  localparam int DW = 32, RW = 5, CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0;
  id_ex_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .COUNT_WIDTH(CW)) bus ();
  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] pc, input logic fl);
    bus.ex_control_in = ex;
    bus.mem_control_in = mem;
    bus.wb_control_in = wb;
    bus.rs_in = rs;
    bus.rt_in = rt;
    bus.rd_in = rd;
    bus.pc_plus4_in = pc;
    bus.read_data1_in = pc ^ 32'h1111_0000;
    bus.read_data2_in = pc ^ 32'h2222_0000;
    bus.sign_ext_imm_in = pc ^ 32'h3333_0000;
    bus.flush = fl;
    #1;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_ctrl(input string tag, input logic [8:0] ctrl, input logic v, input logic [3:0] cnt);
    chk({tag, "_ctrl"}, {bus.ex_control_out, bus.mem_control_out, bus.wb_control_out}, ctrl);
    chk({tag, "_valid"}, bus.valid_out, v);
    chk({tag, "_count"}, bus.bubble_count, cnt);
  endtask
  task automatic chk_wr(input string tag, input logic w);
    chk({tag, "_pcw"}, bus.pc_write, w);
    chk({tag, "_ifidw"}, bus.if_id_write, w);
  endtask
  initial begin
    drive(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    step();
    step();
    chk_ctrl("rst_init", 9'd0, 1'b0, 4'd0);
    rst = 1'b0;
    drive(4'b1010, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3, 32'h0000_0104, 1'b0);
    step();
    chk_ctrl("rform", 9'b1010_000_10, 1'b1, 4'd0);
    chk("rform_pc", bus.pc_plus4_out, 32'h0000_0104);
    chk("rform_rd1", bus.read_data1_out, 32'h1111_0104);
    chk("rform_imm", bus.sign_ext_imm_out, 32'h3333_0104);
    chk("rform_regs", {bus.rs_out, bus.rt_out, bus.rd_out}, {5'd1, 5'd2, 5'd3});
    #3 rst = 1'b1;
    #1;
    chk_ctrl("rst_mid", 9'd0, 1'b0, 4'd0);
    chk("rst_mid_pc", bus.pc_plus4_out, 32'h0);
    chk("rst_mid_rs", bus.rs_out, 5'd0);
    chk_wr("rst_mid", 1'b1);
    rst = 1'b0;
    drive(4'b1010, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3, 32'h0000_0200, 1'b0);
    step();
    chk_ctrl("rel", 9'b1010_000_10, 1'b1, 4'd0);
    drive(4'b0100, 3'b100, 2'b11, 5'd1, 5'd8, 5'd0, 32'h0000_0204, 1'b0);
    chk_wr("lw_pres", 1'b1);
    step();
    chk_ctrl("lw_cap", 9'b0100_100_11, 1'b1, 4'd0);
    drive(4'b1010, 3'b000, 2'b10, 5'd8, 5'd9, 5'd4, 32'h0000_0208, 1'b0);
    chk_wr("lu_stall", 1'b0);
    step();
    chk_ctrl("lu_bub", 9'd0, 1'b0, 4'd1);
    chk_wr("lu_rel", 1'b1);
    step();
    chk_ctrl("lu_add", 9'b1010_000_10, 1'b1, 4'd1);
    chk("lu_add_rs", bus.rs_out, 5'd8);
    drive(4'b0100, 3'b100, 2'b11, 5'd1, 5'd0, 5'd0, 32'h0000_0300, 1'b0);
    step();
    drive(4'b1010, 3'b000, 2'b10, 5'd0, 5'd0, 5'd5, 32'h0000_0304, 1'b0);
    chk_wr("rt0", 1'b1);
    drive(4'b0100, 3'b100, 2'b11, 5'd0, 5'd8, 5'd0, 32'h0000_0308, 1'b0);
    step();
    drive(4'b1010, 3'b000, 2'b10, 5'd9, 5'd10, 5'd5, 32'h0000_030c, 1'b0);
    chk_wr("nodep", 1'b1);
    drive(4'b1010, 3'b000, 2'b10, 5'd9, 5'd8, 5'd5, 32'h0000_030c, 1'b0);
    chk_wr("rtdep", 1'b0);
    drive(4'b1010, 3'b000, 2'b10, 5'd9, 5'd10, 5'd5, 32'h0000_030c, 1'b0);
    step();
    chk_ctrl("nodep_cap", 9'b1010_000_10, 1'b1, 4'd1);
    drive(4'b0100, 3'b010, 2'b00, 5'd1, 5'd8, 5'd0, 32'h0000_0310, 1'b0);
    step();
    drive(4'b1010, 3'b000, 2'b10, 5'd8, 5'd8, 5'd6, 32'h0000_0314, 1'b0);
    chk_wr("sw_dep", 1'b1);
    step();
    chk_ctrl("sw_cap", 9'b1010_000_10, 1'b1, 4'd1);
    drive(4'b1010, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3, 32'h0000_0400, 1'b1);
    chk_wr("fl", 1'b1);
    step();
    chk_ctrl("fl_bub", 9'd0, 1'b0, 4'd2);
    chk("fl_pc", bus.pc_plus4_out, 32'h0000_0400);
    drive(4'b0100, 3'b100, 2'b11, 5'd1, 5'd8, 5'd0, 32'h0000_0404, 1'b0);
    step();
    drive(4'b1010, 3'b000, 2'b10, 5'd8, 5'd2, 5'd3, 32'h0000_0408, 1'b1);
    chk_wr("flhz", 1'b1);
    step();
    chk_ctrl("flhz_bub", 9'd0, 1'b0, 4'd3);
    for (int i = 1; i <= 20; i++) begin
      drive(4'b1010, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3, 32'h0000_0500 + i, 1'b1);
      step();
      if (i == 11) chk("sat_14", bus.bubble_count, 4'd14);
      if (i == 12) chk("sat_15", bus.bubble_count, 4'd15);
    end
    chk_ctrl("sat_end", 9'd0, 1'b0, 4'd15);
    drive(4'b0100, 3'b100, 2'b11, 5'd1, 5'd8, 5'd0, 32'h0000_0600, 1'b0);
    step();
    drive(4'b1010, 3'b000, 2'b10, 5'd8, 5'd2, 5'd3, 32'h0000_0604, 1'b0);
    chk_wr("mid_stall", 1'b0);
    rst = 1'b1;
    #1;
    chk_wr("rst_stall", 1'b1);
    chk_ctrl("rst_stall", 9'd0, 1'b0, 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
